mem_access_unit: RTL and testbench

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. Takes the latched memory-op fields (read/write strobe, address, store data, funct3), drives a single-outstanding request to the data cache with a held-until-response handshake, and stalls the pipeline while the access is in flight. It returns aligned, sign- or zero-extended load data to writeback and counts memory stall cycles.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues one outstanding data-cache request per
// load/store, stalls the pipeline while it is in flight and formats load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // funct3 low bits select the size; every unlisted encoding falls back to word.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (access_size(f3))
      SZ_BYTE: return f3[2] ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: return f3[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: return word;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [31:0] dmem_address_q, dmem_address_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_mbe_q, dmem_mbe_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic        req_s;
  logic [1:0]  size_s;
  logic [1:0]  off_s;
  logic        aligned_s;
  logic        stall_s;
  logic        misaligned_s;

  assign req_s     = mem_read | mem_write;
  assign off_s     = addr[1:0];
  assign size_s    = access_size(funct3);
  assign aligned_s = is_aligned(size_s, off_s);

  // Next-state, request capture, response formatting and stall generation.
  always_comb begin
    state_d        = state_q;
    dmem_read_d    = dmem_read_q;
    dmem_write_d   = dmem_write_q;
    dmem_address_d = dmem_address_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_mbe_d     = dmem_mbe_q;
    funct3_d       = funct3_q;
    offset_d       = offset_q;
    load_data_d    = load_data_q;
    load_valid_d   = 1'b0;
    stall_s        = 1'b0;
    misaligned_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_s && aligned_s) begin
          stall_s        = 1'b1;
          state_d        = BUSY;
          // A simultaneous read and write strobe is resolved as a read.
          dmem_read_d    = mem_read;
          dmem_write_d   = ~mem_read;
          dmem_address_d = {addr[31:2], 2'b00};
          dmem_wdata_d   = wdata << {off_s, 3'b000};
          dmem_mbe_d     = lane_mask(size_s, off_s);
          funct3_d       = funct3;
          offset_d       = off_s;
        end else if (req_s) begin
          misaligned_s   = 1'b1;
        end else begin
          state_d        = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (dmem_resp) begin
          state_d      = DONE;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          if (dmem_read_q) begin
            load_data_d  = format_load(funct3_q, offset_q, dmem_rdata);
            load_valid_d = 1'b1;
          end else begin
            load_valid_d = 1'b0;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // Inputs seen here still belong to the completing instruction.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        dmem_read_d  = 1'b0;
        dmem_write_d = 1'b0;
      end
    endcase

    stall_cycles_d = stall_cycles_q + {31'd0, stall_s};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= 32'd0;
      dmem_wdata_q   <= 32'd0;
      dmem_mbe_q     <= 4'd0;
      funct3_q       <= 3'd0;
      offset_q       <= 2'd0;
      load_data_q    <= 32'd0;
      load_valid_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      dmem_read_q    <= dmem_read_d;
      dmem_write_q   <= dmem_write_d;
      dmem_address_q <= dmem_address_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_mbe_q     <= dmem_mbe_d;
      funct3_q       <= funct3_d;
      offset_q       <= offset_d;
      load_data_q    <= load_data_d;
      load_valid_q   <= load_valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign dmem_read    = dmem_read_q;
  assign dmem_write   = dmem_write_q;
  assign dmem_address = dmem_address_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_mbe     = dmem_mbe_q;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign stall_cycles = stall_cycles_q;
  assign stall        = stall_s & ~rst;
  assign misaligned   = misaligned_s & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver queues expected cache requests
// and load results, a negedge monitor plays the cache and checks what it sees.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        stall, load_valid, misaligned;
  logic [31:0] load_data, stall_cycles;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    int          lat;
    logic [31:0] rdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  req_t        cur;
  req_t        rr;
  int          busy = 0;
  int          inject_cnt = 0;
  int          inject_seen = 0;
  int          stall_total = 0;
  logic [31:0] last_load = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference load: pick the addressed bytes, then extend by funct3 bit 2.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    int nb;
    nb = size_of(f3);
    v  = rdata >> (8 * a[1:0]);
    if (nb == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Cache model and output monitor.
  always @(negedge clk) begin
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    if (load_valid === 1'b1) begin
      if (load_q.size() == 0) begin
        check("spurious_load_valid", 32'(load_valid), 32'd0);
      end else begin
        check("load_data", load_data, load_q.pop_front());
      end
    end
    if (dmem_read || dmem_write) begin
      if (busy == 0) begin
        if (req_q.size() == 0) begin
          check("spurious_request", 32'({dmem_read, dmem_write}), 32'd0);
          cur.rd = dmem_read; cur.wr = dmem_write; cur.addr = dmem_address;
          cur.wdata = dmem_wdata; cur.mbe = dmem_mbe; cur.lat = 1; cur.rdata = 32'd0;
        end else begin
          cur = req_q.pop_front();
        end
      end
      check("req_read", 32'(dmem_read), 32'(cur.rd));
      check("req_write", 32'(dmem_write), 32'(cur.wr));
      check("req_address", dmem_address, cur.addr);
      check("req_mbe", 32'(dmem_mbe), 32'(cur.mbe));
      if (cur.wr) check("req_wdata", dmem_wdata, cur.wdata);
      busy++;
      if (busy == cur.lat) begin
        dmem_resp  = 1'b1;
        dmem_rdata = cur.rdata;
      end
    end else begin
      busy = 0;
      if (inject_cnt != inject_seen) begin
        inject_seen++;
        dmem_resp = 1'b1;
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int lat);
    int   nb;
    int   n;
    req_t r;
    @(negedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    nb = size_of(f3);
    #1;
    if ((int'(a[1:0]) % nb) != 0) begin
      check("misaligned_flag", 32'(misaligned), 32'd1);
      check("misaligned_stall", 32'(stall), 32'd0);
      @(negedge clk); #1;
      check("misaligned_no_req", 32'(dmem_read | dmem_write), 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    r.rd    = rd;
    r.wr    = !rd;
    r.addr  = a & 32'hFFFF_FFFC;
    r.wdata = wd << (8 * a[1:0]);
    r.mbe   = (nb == 4) ? 4'hF : (nb == 2) ? (4'h3 << a[1:0]) : (4'h1 << a[1:0]);
    r.lat   = lat;
    r.rdata = rdata;
    req_q.push_back(r);
    if (rd) begin
      last_load = ref_load(f3, a, rdata);
      load_q.push_back(last_load);
    end
    check("aligned_flag", 32'(misaligned), 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      @(negedge clk); #1;
    end
    check("stall_no_timeout", 32'(n < 60), 32'd1);
    check("stall_len", 32'(n), 32'(lat + 1));
    check("done_no_req", 32'(dmem_read | dmem_write), 32'd0);
    stall_total += lat + 1;
    check("stall_cycles", stall_cycles, 32'(stall_total));
    if (!rd) begin
      check("store_no_load_valid", 32'(load_valid), 32'd0);
      check("load_data_hold", load_data, last_load);
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0001; wdata = 32'd0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_dmem_read", 32'(dmem_read), 32'd0);
    check("rst_dmem_write", 32'(dmem_write), 32'd0);
    check("rst_address", dmem_address, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mbe", 32'(dmem_mbe), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    rst = 1'b0; mem_read = 1'b0;

    access(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1);
    check("lw_value", load_data, 32'hDEAD_BEEF);
    check("lw_stall_total", stall_cycles, 32'd2);
    access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 2);
    check("lb_value", load_data, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 1);
    check("lbu_value", load_data, 32'h0000_0080);
    access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 3);
    access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 32'd0, 1);
    access(1'b1, 1'b0, 3'b001, 32'h0000_2003, 32'd0, 32'd0, 1);

    // Reset in the middle of an access, followed by a stray response.
    @(negedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_3000;
    rr.rd = 1'b1; rr.wr = 1'b0; rr.addr = 32'h0000_3000; rr.wdata = 32'd0;
    rr.mbe = 4'hF; rr.lat = 6; rr.rdata = 32'h1111_2222;
    req_q.push_back(rr);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("busy_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_forces_stall_low", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("midrst_dmem_read", 32'(dmem_read), 32'd0);
    check("midrst_address", dmem_address, 32'd0);
    check("midrst_load_valid", 32'(load_valid), 32'd0);
    check("midrst_stall_cycles", stall_cycles, 32'd0);
    rst = 1'b0; mem_read = 1'b0;
    stall_total = 0; last_load = 32'd0;
    inject_cnt++;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("late_resp_no_load_valid", 32'(load_valid), 32'd0);
    check("late_resp_no_req", 32'(dmem_read | dmem_write), 32'd0);
    check("late_resp_idle", 32'(stall), 32'd0);

    access(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'd0, 32'h1234_F00D, 1);
    check("lh_value", load_data, 32'hFFFF_F00D);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'hCAFE_0001, 1);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'h5555_AAAA, 32'd0, 1);
    access(1'b1, 1'b1, 3'b010, 32'h0000_0048, 32'h0BAD_0BAD, 32'h0123_4567, 2);

    for (int i = 0; i < 60; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = !rd || ($urandom_range(0, 3) == 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
      access(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(1, 4)));
    end

    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("load_queue_drained", 32'(load_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
